// File: rtl/div_post_proc_pipe_pkg.sv
// div_post_proc_pipe_pkg: shared types and constants for the divider post-processing pipe.
package div_post_proc_pipe_pkg;

    localparam int DIV_XLEN   = 64;
    localparam int DIV_ITER_W = 6;
    localparam int DIV_TAG_W  = 5;
    localparam int REM_W      = DIV_XLEN + 3;

    localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q    = '1;
    localparam int                  WORD_SIGN_BIT = 31;

    typedef struct packed {
        logic q_neg;
        logic rem_neg;
        logic div_zero;
        logic overflow;
        logic is_word;
    } div_flags_t;

    typedef struct packed {
        logic [DIV_TAG_W-1:0]  tag;
        logic                  odd_leading_zero;
        logic [DIV_ITER_W-1:0] iter_val;
        logic [REM_W-1:0]      sum;
        logic [REM_W-1:0]      carry;
        logic [REM_W-1:0]      q;
        logic [REM_W-1:0]      shifted_b;
        div_flags_t            flags;
        logic [DIV_XLEN-1:0]   dividend;
    } div_post_req_t;

endpackage

// File: rtl/div_post_proc_pipe_if.sv
// div_post_proc_pipe_if: request/response handshake bundle of the divider post-processing pipe.
interface div_post_proc_pipe_if #(
    parameter int XLEN   = 64,
    parameter int ITER_W = 6,
    parameter int TAG_W  = 5
);
    localparam int RW = XLEN + 3;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [TAG_W-1:0]  in_tag;
    logic              odd_leading_zero;
    logic [ITER_W-1:0] iter_val;
    logic [RW-1:0]     last_iter_sum;
    logic [RW-1:0]     last_iter_carry;
    logic [RW-1:0]     last_iter_q;
    logic [RW-1:0]     shifted_b;
    logic              q_neg;
    logic              rem_neg;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   dividend;
    logic              is_word;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   rem;

    modport master (
        output flush, in_valid, in_tag, odd_leading_zero, iter_val, last_iter_sum,
               last_iter_carry, last_iter_q, shifted_b, q_neg, rem_neg, div_zero,
               overflow, dividend, is_word, out_ready,
        input  in_ready, out_valid, out_tag, q, rem
    );

    modport slave (
        input  flush, in_valid, in_tag, odd_leading_zero, iter_val, last_iter_sum,
               last_iter_carry, last_iter_q, shifted_b, q_neg, rem_neg, div_zero,
               overflow, dividend, is_word, out_ready,
        output in_ready, out_valid, out_tag, q, rem
    );

endinterface

// File: rtl/div_post_proc_pipe_rem_correct.sv
// div_rem_correct: stage-2 remainder select/shift, quotient fixup, sign, word-extend and special cases.
module div_rem_correct
    import div_post_proc_pipe_pkg::*;
#(
    parameter int XLEN   = DIV_XLEN,
    parameter int ITER_W = DIV_ITER_W
) (
    input  logic [XLEN+2:0]   rem_nc,
    input  logic [XLEN+2:0]   rem_c,
    input  logic              neg,
    input  logic [XLEN-1:0]   q_tmp,
    input  logic [ITER_W-1:0] iter_val,
    input  div_flags_t        flags,
    input  logic [XLEN-1:0]   dividend,
    output logic [XLEN-1:0]   q,
    output logic [XLEN-1:0]   rem
);
    localparam int SH = XLEN - 1 - WORD_SIGN_BIT;

    logic [XLEN+2:0] sel;
    logic [XLEN-1:0] r, qm, qs, rs, dw;

    // Sign-extend from bit 31 by shifting it to the MSB and back arithmetically.
    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v);
        return $signed(v << SH) >>> SH;
    endfunction

    always_comb begin
        sel = neg ? rem_c : rem_nc;
        r   = XLEN'($signed(sel) >>> {iter_val, 1'b0});
        qm  = neg ? q_tmp - XLEN'(1) : q_tmp;
        qs  = flags.q_neg ? -qm : qm;
        rs  = flags.rem_neg ? -r : r;
        dw  = flags.is_word ? wext(dividend) : dividend;
        q   = flags.div_zero ? DIV_ZERO_Q[XLEN-1:0] : flags.overflow ? dw : flags.is_word ? wext(qs) : qs;
        rem = flags.div_zero ? dw : flags.overflow ? '0 : flags.is_word ? wext(rs) : rs;
    end

endmodule

// File: rtl/div_post_proc_pipe.sv
// div_post_proc_pipe: two-stage SRT divider post-processing with valid/ready handshake and flush.
module div_post_proc_pipe
    import div_post_proc_pipe_pkg::*;
#(
    parameter int XLEN   = DIV_XLEN,
    parameter int ITER_W = DIV_ITER_W,
    parameter int TAG_W  = DIV_TAG_W
) (
    input logic clk,
    input logic rst_n,
    div_post_proc_pipe_if.slave bus
);
    localparam int RW = XLEN + 3;

    logic              s1_valid, s2_valid, s1_adv, s2_adv, accept;
    logic [RW-1:0]     rem_nc;
    logic [RW-1:0]     s1_rem_nc, s1_rem_c;
    logic              s1_neg;
    logic [XLEN-1:0]   s1_q, s1_dividend;
    logic [ITER_W-1:0] s1_iter;
    logic [TAG_W-1:0]  s1_tag, s2_tag;
    div_flags_t        s1_flags;
    logic [XLEN-1:0]   q_nxt, rem_nxt, s2_q, s2_rem;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign accept       = s1_adv && bus.in_valid;
    assign rem_nc       = bus.last_iter_sum + bus.last_iter_carry;
    assign bus.in_ready = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_tag  = s2_tag;
    assign bus.q        = s2_q;
    assign bus.rem      = s2_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= bus.in_valid;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // Stage-1 payload only needs to be meaningful while s1_valid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_rem_nc   <= rem_nc;
            s1_rem_c    <= rem_nc + bus.shifted_b;
            s1_neg      <= rem_nc[RW-1];
            s1_q        <= XLEN'(bus.odd_leading_zero ? bus.last_iter_q >> 1 : bus.last_iter_q);
            s1_iter     <= bus.iter_val;
            s1_tag      <= bus.in_tag;
            s1_dividend <= bus.dividend;
            s1_flags    <= '{q_neg: bus.q_neg, rem_neg: bus.rem_neg, div_zero: bus.div_zero,
                             overflow: bus.overflow, is_word: bus.is_word};
        end
    end

    div_rem_correct #(.XLEN(XLEN), .ITER_W(ITER_W)) u_corr (
        .rem_nc   (s1_rem_nc),
        .rem_c    (s1_rem_c),
        .neg      (s1_neg),
        .q_tmp    (s1_q),
        .iter_val (s1_iter),
        .flags    (s1_flags),
        .dividend (s1_dividend),
        .q        (q_nxt),
        .rem      (rem_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q   <= '0;
            s2_rem <= '0;
            s2_tag <= '0;
        end else if (s2_adv && s1_valid) begin
            s2_q   <= q_nxt;
            s2_rem <= rem_nxt;
            s2_tag <= s1_tag;
        end
    end

endmodule

// File: tb/tb_div_post_proc_pipe.sv
// tb_div_post_proc_pipe: vector table with scoreboard, plus backpressure and flush sequences.
module tb_div_post_proc_pipe;
    import div_post_proc_pipe_pkg::*;

    typedef struct {
        div_post_req_t req;
        logic [63:0]   eq;
        logic [63:0]   erem;
    } vec_t;

    typedef struct packed {
        logic [4:0]  tag;
        logic [63:0] q;
        logic [63:0] rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur_exp;
    vec_t vt[15];
    logic stall_prev = 1'b0;
    exp_t prev_out;

    div_post_proc_pipe_if #(.XLEN(64), .ITER_W(6), .TAG_W(5)) b ();

    div_post_proc_pipe #(.XLEN(64), .ITER_W(6), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] tag, input logic olz, input logic [5:0] iter,
                                input logic [REM_W-1:0] sum, input logic [REM_W-1:0] carry,
                                input logic [REM_W-1:0] qraw, input logic [REM_W-1:0] sb_in,
                                input logic [4:0] fl, input logic [63:0] dvd,
                                input logic [63:0] eq, input logic [63:0] erem);
        vec_t v;
        v.req.tag              = tag;
        v.req.odd_leading_zero = olz;
        v.req.iter_val         = iter;
        v.req.sum              = sum;
        v.req.carry            = carry;
        v.req.q                = qraw;
        v.req.shifted_b        = sb_in;
        v.req.flags            = fl;
        v.req.dividend         = dvd;
        v.eq                   = eq;
        v.erem                 = erem;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        b.in_tag           = v.req.tag;
        b.odd_leading_zero = v.req.odd_leading_zero;
        b.iter_val         = v.req.iter_val;
        b.last_iter_sum    = v.req.sum;
        b.last_iter_carry  = v.req.carry;
        b.last_iter_q      = v.req.q;
        b.shifted_b        = v.req.shifted_b;
        b.q_neg            = v.req.flags.q_neg;
        b.rem_neg          = v.req.flags.rem_neg;
        b.div_zero         = v.req.flags.div_zero;
        b.overflow         = v.req.flags.overflow;
        b.is_word          = v.req.flags.is_word;
        b.dividend         = v.req.dividend;
        cur_exp.tag        = v.req.tag;
        cur_exp.q          = v.eq;
        cur_exp.rem        = v.erem;
    endtask

    task automatic send(input vec_t v);
        drive(v);
        b.in_valid = 1'b1;
        for (int n = 0; n < 100 && !b.in_ready; n++) @(negedge clk);
        chk("send_in_ready", 64'(b.in_ready), 64'd1);
        @(posedge clk);
        #1 b.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard push on every real accept; flushed-cycle inputs are dropped.
    always @(posedge clk)
        if (rst_n && b.in_valid && b.in_ready && !b.flush) sb.push_back(cur_exp);

    always @(negedge clk) begin
        if (rst_n && b.out_valid) begin
            if (stall_prev) begin
                checks++;
                if ({b.out_tag, b.q, b.rem} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h", {b.out_tag, b.q, b.rem}, prev_out);
                end
            end
            if (b.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: tag %0d q %h rem %h with empty scoreboard", b.out_tag, b.q, b.rem);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tag", 64'(b.out_tag), 64'(e.tag));
                    chk($sformatf("q[tag %0d]", e.tag), b.q, e.q);
                    chk($sformatf("rem[tag %0d]", e.tag), b.rem, e.rem);
                end
            end
            stall_prev = !b.out_ready;
            prev_out   = {b.out_tag, b.q, b.rem};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(1, 0, 1, 8, 0, 14, 28, 5'b00000, 0, 14, 2);
        vt[1]  = mk(2, 0, 1, REM_W'(-20), 0, 15, 28, 5'b00000, 0, 14, 2);
        vt[2]  = mk(3, 1, 1, 8, 0, 28, 28, 5'b00000, 0, 14, 2);
        vt[3]  = mk(4, 0, 1, 12, 0, 5, 28, 5'b11001, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFD);
        vt[4]  = mk(5, 0, 1, 0, 0, 0, 0, 5'b00100, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        vt[5]  = mk(6, 0, 1, 0, 0, 0, 0, 5'b00010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
        vt[6]  = mk(7, 0, 1, 0, 0, 0, 0, 5'b00101, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005);
        vt[7]  = mk(8, 0, 1, 40, 60, 7, 28, 5'b00000, 0, 7, 25);
        vt[8]  = mk(9, 0, 3, 320, 0, 9, 28, 5'b10000, 0, 64'hFFFF_FFFF_FFFF_FFF7, 5);
        vt[9]  = mk(10, 0, 1, 0, 0, 0, 28, 5'b11000, 0, 0, 0);
        vt[10] = mk(11, 0, 1, 0, 0, 0, 0, 5'b00011, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 0);
        vt[11] = mk(12, 0, 1, 0, 0, 0, 0, 5'b00110, 7, 64'hFFFF_FFFF_FFFF_FFFF, 7);
        vt[12] = mk(13, 0, 1, 67'h4_0000_0008, 0, 67'h1_0000_0003, 28, 5'b00001, 0, 3, 2);
        vt[13] = mk(14, 0, 1, REM_W'(-28), REM_W'(-4), 1, 28, 5'b00000, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        vt[14] = mk(15, 1, 2, 96, 0, 67'h2_0000_0000_0000_0014, 28, 5'b00000, 0, 10, 6);

        rst_n       = 1'b0;
        b.flush     = 1'b0;
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        drive(vt[0]);
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(b.out_valid), 0);
        chk("reset_q", b.q, 0);
        chk("reset_rem", b.rem, 0);
        chk("reset_out_tag", 64'(b.out_tag), 0);
        rst_n = 1'b1;
        #1 chk("reset_in_ready", 64'(b.in_ready), 1);

        // Two-cycle latency from accept edge to out_valid.
        send(vt[0]);
        @(negedge clk) chk("latency_c1_out_valid", 64'(b.out_valid), 0);
        @(negedge clk) chk("latency_c2_out_valid", 64'(b.out_valid), 1);
        drain();

        foreach (vt[i]) send(vt[i]);
        drain();

        // Backpressure: third input must wait until the consumer drains.
        @(negedge clk) b.out_ready = 1'b0;
        send(vt[3]);
        send(vt[4]);
        drive(vt[5]);
        b.in_valid = 1'b1;
        #1 chk("bp_in_ready_low", 64'(b.in_ready), 0);
        repeat (3) @(negedge clk);
        chk("bp_in_ready_still_low", 64'(b.in_ready), 0);
        chk("bp_head_tag", 64'(b.out_tag), 64'(vt[3].req.tag));
        b.out_ready = 1'b1;
        @(posedge clk);
        #1 b.in_valid = 1'b0;
        drain();

        // Flush with two ops in flight and a same-cycle input that must be dropped.
        @(negedge clk) b.out_ready = 1'b0;
        send(vt[7]);
        send(vt[8]);
        chk("pre_flush_out_valid", 64'(b.out_valid), 1);
        drive(vt[9]);
        b.in_valid = 1'b1;
        b.flush    = 1'b1;
        @(posedge clk);
        #1;
        b.flush    = 1'b0;
        b.in_valid = 1'b0;
        chk("flush_out_valid", 64'(b.out_valid), 0);
        sb.delete();
        b.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_flush_out_valid", 64'(b.out_valid), 0);
        send(vt[14]);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
